// File: rtl/sync_circular_fifo.sv
// Single-clock circular-buffer FIFO with registered read data.
// Flags and occupancy are decoded from wrap-flagged read/write pointers.
//
// Ports:
//   FCLK         clock, rising edge
//   FRSTN        synchronous reset, active-high
//   WR_EN        write request
//   RD_EN        read request
//   DATA_IN      write data
//   DATA_OUT     registered read data, valid the cycle after the accepting edge
//   EMPTY        zero entries held
//   FULL         DEPTH entries held
//   ALMOST_FULL  COUNT >= ALMOST_FULL_TH
//   ALMOST_EMPTY COUNT <= ALMOST_EMPTY_TH
//   COUNT        occupancy, 0..DEPTH
//   OVERFLOW     one-cycle pulse after a write rejected while full
//   UNDERFLOW    one-cycle pulse after a read rejected while empty
module sync_circular_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 16,
  parameter int ADDR_WIDTH      = $clog2(DEPTH),
  parameter int ALMOST_FULL_TH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  FCLK,
  input  logic                  FRSTN,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam logic [ADDR_WIDTH:0] AF_TH =
    ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH =
    ALMOST_EMPTY_TH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // MSB of each pointer is a wrap flag; the rest indexes mem.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;

  logic wr_ok;
  logic rd_ok;

  assign wr_idx = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_idx = rd_ptr[ADDR_WIDTH-1:0];

  assign EMPTY = (wr_ptr == rd_ptr);
  assign FULL  = (wr_idx == rd_idx) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign COUNT        = wr_ptr - rd_ptr;
  assign ALMOST_FULL  = (COUNT >= AF_TH);
  assign ALMOST_EMPTY = (COUNT <= AE_TH);

  // Acceptance uses the flags of the current cycle, so a read on an
  // empty FIFO never falls through to a same-cycle write.
  assign wr_ok = WR_EN && !FULL;
  assign rd_ok = RD_EN && !EMPTY;

  always_ff @(posedge FCLK) begin
    if (FRSTN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      DATA_OUT  <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= WR_EN && FULL;
      UNDERFLOW <= RD_EN && EMPTY;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        DATA_OUT <= mem[rd_idx];
      end
    end
  end

  // Storage is left uncleared by reset; pointers alone define contents.
  always_ff @(posedge FCLK) begin
    if (!FRSTN && wr_ok) begin
      mem[wr_idx] <= DATA_IN;
    end
  end

endmodule

// File: tb/tb_sync_circular_fifo.sv
// Directed bench for sync_circular_fifo.
// Queue scoreboard holds accepted writes; reads pop and compare.
module tb_sync_circular_fifo;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int AW  = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic          afull;
  logic          aempty;
  logic [AW:0]   count;
  logic          ovf;
  logic          unf;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;

  sync_circular_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEP)
  ) dut (
    .FCLK(clk),
    .FRSTN(rst),
    .WR_EN(wr_en),
    .RD_EN(rd_en),
    .DATA_IN(din),
    .DATA_OUT(dout),
    .EMPTY(empty),
    .FULL(full),
    .ALMOST_FULL(afull),
    .ALMOST_EMPTY(aempty),
    .COUNT(count),
    .OVERFLOW(ovf),
    .UNDERFLOW(unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEP));
    chk("almost_full", 32'(afull), 32'(n >= DEP - 2));
    chk("almost_empty", 32'(aempty), 32'(n <= 2));
    chk("data_out", 32'(dout), 32'(exp_dout));
    chk("overflow", 32'(ovf), 32'(exp_ovf));
    chk("underflow", 32'(unf), 32'(exp_unf));
  endtask

  task automatic cycle(input logic wr,
                       input logic rd,
                       input logic [DW-1:0] d);
    logic m_full;
    logic m_empty;
    m_full  = (q.size() == DEP);
    m_empty = (q.size() == 0);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    exp_ovf = wr && m_full;
    exp_unf = rd && m_empty;
    if (rd && !m_empty) exp_dout = q.pop_front();
    if (wr && !m_full) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    check_all();
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;

    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'h55);
    cycle(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);

    cycle(1'b1, 1'b1, 8'h77);
    cycle(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    cycle(1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
    do_reset();
    cycle(1'b1, 1'b0, 8'hEE);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
